plot_sequencer: RTL and testbench
=================================

# plot_sequencer

Parametrised frame sequencer for the tuner's VGA display path. On each frame tick it runs clear, then letter, then one graph pass per enabled note channel, and hands a channel index to the shared graph plotter. It replaces the fixed single-graph controller. It sits between the half-second tick generator and the clear, letter and graph datapath plotters.

## Interface
- NUM_CH, 13, number of note graph channels (A4 … A5); legal 1–32
- CH_W, $clog2(NUM_CH) (min 1), width of channel index
- WDOG_W, 20, watchdog counter width (used only with watchdog compiled in)
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse; request a new frame
- ch_en_mask  in  NUM_CH  bit i=1 → draw graph for channel i
- done_clear  in  1  clear plotter finished
- done_plot_letter  in  1  letter plotter finished
- done_plot_graph  in  1  graph plotter finished current channel
- ld_clear  out  1  enable clear plotter
- ld_letter  out  1  enable letter plotter
- ld_graph  out  1  enable graph plotter
- graph_ch  out  CH_W  channel the graph plotter must draw; valid while ld_graph
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse at end of frame
- frame_overrun  out  1  one-cycle pulse: frame_tick arrived while busy
- timeout_err  out  1  sticky watchdog flag (0 when watchdog compiled out)
- current_state  out  3  state encoding, debug

## Operation
- States: S_IDLE(0), S_CLEAR(1), S_LETTER(2), S_GRAPH(3), S_DONE(4). Encodings 5–7 are illegal and go to S_IDLE.
- S_IDLE: on frame_tick, latch ch_en_mask into mask_q and go to S_CLEAR.
- S_CLEAR: on done_clear, go to S_LETTER.
- S_LETTER: on done_plot_letter, go to S_GRAPH with ch_q = lowest set bit of mask_q. If mask_q==0, go to S_DONE and skip graphs.
- S_GRAPH: on done_plot_graph, set ch_q = lowest set bit of mask_q strictly above ch_q and stay. If no such bit exists, go to S_DONE. There is no wrap-around.
- S_DONE: frame_done=1 for exactly one cycle, then go to S_IDLE.
- ld_clear, ld_letter and ld_graph are Moore outputs: one-hot in states 1/2/3, all 0 otherwise. graph_ch = ch_q.
- busy = (state != S_IDLE).
- done_* inputs are honoured only in their own state and ignored elsewhere.
- frame_tick in any state other than S_IDLE is dropped and pulses frame_overrun for one cycle.
- ch_en_mask changes mid-frame have no effect; only mask_q is used.
- Reset values: state=S_IDLE, mask_q=0, ch_q=0. All outputs are 0 (current_state=0, graph_ch=0, timeout_err=0).
- resetn asserted mid-frame aborts immediately with no frame_done.

## Timing
- All state and flag registers update on posedge clk. Outputs are registered-state decodes with no input-to-output combinational path, except frame_overrun, which is registered (asserted the cycle after the dropped tick).
- frame_tick at cycle T: ld_clear=1 from T+1.
- done_x at cycle T: the next stage's ld is high from T+1, and the previous ld is low from T+1.
- Minimum frame with K enabled channels: 1 (CLEAR) + 1 (LETTER) + K (GRAPH) + 1 (DONE) cycles, with every done returned the first cycle.
- graph_ch changes in the same cycle ld_graph stays high for the next channel. The plotter must restart on a graph_ch change.

## Configuration
- PLOT_SEQ_WATCHDOG_EN defined:
  - A WDOG_W-bit counter clears on every state change and increments in S_CLEAR, S_LETTER and S_GRAPH.
  - When it reaches all-ones, the FSM advances exactly as if the stage's done had arrived, and timeout_err is set.
  - timeout_err is sticky and clears only on resetn.
- Not defined: there is no counter, the FSM waits indefinitely, and timeout_err is tied to 0.

## Structure
- Package plot_seq_pkg holds:
  - the state localparams S_IDLE..S_DONE
  - the state width (3)
  - a default NUM_CH=13 constant
- One sub-module, plot_seq_next_ch: a combinational priority finder.
  - Inputs: mask, ch, first.
  - Outputs: next_ch, found.
  - first=1 returns the lowest set bit; otherwise it returns the lowest set bit strictly above ch.

## Test plan
- Mask 13'h1FFF, done pulses every cycle → ld sequence clear, letter, graph×13 with graph_ch 0..12, frame_done 16 cycles after tick, busy low after.
- Mask 13'b0000100000101 → graph_ch visits 0, 2, 8 only, then frame_done.
- Mask 0 → letter done goes straight to S_DONE; ld_graph never asserts.
- frame_tick during S_GRAPH → frame_overrun pulses once; the frame completes unchanged. Mask change mid-frame is ignored.
- resetn low while in S_GRAPH ch 5 → all outputs 0 asynchronously; no frame_done. After release, the next tick starts at S_CLEAR.
- With PLOT_SEQ_WATCHDOG_EN, WDOG_W=4, done_clear withheld → S_LETTER entered 15 cycles after S_CLEAR entry; timeout_err=1 and holds through later frames.

Source files
------------

// File: rtl/plot_seq_pkg.sv
// Shared constants and state encoding for the frame plot sequencer.
package plot_seq_pkg;

  localparam int unsigned STATE_W        = 3;
  localparam int unsigned NUM_CH_DEFAULT = 13;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LETTER = 3'd2,
    S_GRAPH  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/plot_seq_next_ch.sv
// Priority finder: lowest set mask bit, or lowest set bit strictly above ch.
module plot_seq_next_ch #(
  parameter int unsigned NUM_CH = 13,
  parameter int unsigned CH_W   = 4
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   ch,
  input  logic              first,
  output logic [CH_W-1:0]   next_ch,
  output logic              found
);

  always_comb begin
    next_ch = '0;
    found   = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (!found && mask[i] && (first || (int'(ch) < i))) begin
        next_ch = CH_W'(i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/plot_sequencer.sv
// Frame sequencer: clear, letter, then one graph pass per enabled channel.
// Optional stage watchdog compiled in with PLOT_SEQ_WATCHDOG_EN.
module plot_sequencer
  import plot_seq_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEFAULT,
  parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int unsigned WDOG_W = 20
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               frame_tick,
  input  logic [NUM_CH-1:0]  ch_en_mask,
  input  logic               done_clear,
  input  logic               done_plot_letter,
  input  logic               done_plot_graph,
  output logic               ld_clear,
  output logic               ld_letter,
  output logic               ld_graph,
  output logic [CH_W-1:0]    graph_ch,
  output logic               busy,
  output logic               frame_done,
  output logic               frame_overrun,
  output logic               timeout_err,
  output logic [STATE_W-1:0] current_state
);

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_W-1:0]   nx_ch;
  logic              nx_found;
  logic              stage_done;
  logic              wdog_to;

  plot_seq_next_ch #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_next_ch (
    .mask    (mask_q),
    .ch      (ch_q),
    .first   (state_q == S_LETTER),
    .next_ch (nx_ch),
    .found   (nx_found)
  );

  // State and frame-context registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ch_q    <= ch_d;
    end
  end

  // Next-state logic; a watchdog expiry stands in for the stage's done
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    ch_d       = ch_q;
    stage_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          mask_d  = ch_en_mask;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        stage_done = done_clear | wdog_to;
        if (stage_done) state_d = S_LETTER;
      end
      S_LETTER: begin
        stage_done = done_plot_letter | wdog_to;
        if (stage_done) begin
          if (nx_found) begin
            ch_d    = nx_ch;
            state_d = S_GRAPH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_GRAPH: begin
        stage_done = done_plot_graph | wdog_to;
        if (stage_done) begin
          if (nx_found) ch_d = nx_ch;
          else          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered Moore decodes of the next state, plus the overrun pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ld_clear      <= 1'b0;
      ld_letter     <= 1'b0;
      ld_graph      <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      ld_clear      <= (state_d == S_CLEAR);
      ld_letter     <= (state_d == S_LETTER);
      ld_graph      <= (state_d == S_GRAPH);
      busy          <= (state_d != S_IDLE);
      frame_done    <= (state_d == S_DONE);
      frame_overrun <= frame_tick && (state_q != S_IDLE);
    end
  end

  assign graph_ch      = ch_q;
  assign current_state = state_q;

`ifdef PLOT_SEQ_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog_q;
  logic              timeout_q;
  logic              stage_active;

  assign stage_active = (state_q == S_CLEAR) || (state_q == S_LETTER) ||
                        (state_q == S_GRAPH);
  // Counter is 0 on stage entry; expiry fires as it steps onto all-ones
  assign wdog_to      = stage_active &&
                        (wdog_q == {{(WDOG_W-1){1'b1}}, 1'b0});

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state_d != state_q) || stage_done) wdog_q <= '0;
      else if (stage_active)                  wdog_q <= wdog_q + WDOG_W'(1);
      if (wdog_to) timeout_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_q;
`else
  localparam int unsigned unused_wdog_w = WDOG_W;

  assign wdog_to     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_plot_sequencer.sv
// Scoreboard bench for plot_sequencer: driver queues expected output cycles,
// a negedge monitor pops and compares whenever the DUT shows activity.
module tb_plot_sequencer;

  localparam int unsigned NUM_CH = 13;
  localparam int unsigned CH_W   = 4;
`ifdef PLOT_SEQ_WATCHDOG_EN
  localparam int unsigned TB_WDOG_W = 4;
`else
  localparam int unsigned TB_WDOG_W = 20;
`endif

  typedef struct packed {
    logic       clr;
    logic       lt;
    logic       gr;
    logic [3:0] ch;
    logic       fd;
    logic       ovr;
    logic       busy;
    logic [2:0] st;
    logic       to;
  } ev_t;

  logic              clk;
  logic              resetn;
  logic              frame_tick;
  logic [NUM_CH-1:0] ch_en_mask;
  logic              done_clear;
  logic              done_plot_letter;
  logic              done_plot_graph;
  logic              ld_clear;
  logic              ld_letter;
  logic              ld_graph;
  logic [CH_W-1:0]   graph_ch;
  logic              busy;
  logic              frame_done;
  logic              frame_overrun;
  logic              timeout_err;
  logic [2:0]        current_state;

  ev_t sb_q[$];
  ev_t mon_act;
  ev_t mon_exp;
  int  n_cmp = 0;
  int  n_err = 0;
  logic exp_to = 1'b0;

  plot_sequencer #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W),
    .WDOG_W (TB_WDOG_W)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .frame_tick       (frame_tick),
    .ch_en_mask       (ch_en_mask),
    .done_clear       (done_clear),
    .done_plot_letter (done_plot_letter),
    .done_plot_graph  (done_plot_graph),
    .ld_clear         (ld_clear),
    .ld_letter        (ld_letter),
    .ld_graph         (ld_graph),
    .graph_ch         (graph_ch),
    .busy             (busy),
    .frame_done       (frame_done),
    .frame_overrun    (frame_overrun),
    .timeout_err      (timeout_err),
    .current_state    (current_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ev_t mk(input logic [2:0] st, input logic [3:0] ch, input logic to);
    ev_t e;
    e.clr  = (st == 3'd1);
    e.lt   = (st == 3'd2);
    e.gr   = (st == 3'd3);
    e.ch   = (st == 3'd3) ? ch : 4'd0;
    e.fd   = (st == 3'd4);
    e.ovr  = 1'b0;
    e.busy = 1'b1;
    e.st   = st;
    e.to   = to;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: active cycles pop the scoreboard, idle cycles must show idle
  always @(negedge clk) begin
    if (resetn) begin
      mon_act.clr  = ld_clear;
      mon_act.lt   = ld_letter;
      mon_act.gr   = ld_graph;
      mon_act.ch   = ld_graph ? graph_ch : 4'd0;
      mon_act.fd   = frame_done;
      mon_act.ovr  = frame_overrun;
      mon_act.busy = busy;
      mon_act.st   = current_state;
      mon_act.to   = timeout_err;
      n_cmp++;
      if (ld_clear | ld_letter | ld_graph | frame_done | frame_overrun) begin
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event: got %h with nothing expected", mon_act);
        end else begin
          mon_exp = sb_q.pop_front();
          if (mon_act !== mon_exp) begin
            n_err++;
            $display("FAIL event @%0t: got %h expected %h", $time, mon_act, mon_exp);
          end
        end
      end else if ({busy, current_state, timeout_err} !== {1'b0, 3'd0, exp_to}) begin
        n_err++;
        $display("FAIL idle @%0t: got busy=%b st=%0d to=%b expected busy=0 st=0 to=%b",
                 $time, busy, current_state, timeout_err, exp_to);
      end
    end
  end

  // One frame: ovr_at>0 injects a tick so overrun shows on entry ovr_at;
  // done_clear withheld for clr_wait cycles of S_CLEAR.
  task automatic run_frame(input logic [12:0] m, input int ovr_at,
                           input logic [12:0] alt, input int clr_wait);
    ev_t  eq[$];
    ev_t  tmp;
    int   n_clear;
    int   len;
    logic to_after;
    n_clear  = clr_wait + 1;
    to_after = exp_to;
`ifdef PLOT_SEQ_WATCHDOG_EN
    if (n_clear > 15) begin
      n_clear  = 15;
      to_after = 1'b1;
    end
`endif
    for (int i = 0; i < n_clear; i++) eq.push_back(mk(3'd1, 4'd0, exp_to));
    eq.push_back(mk(3'd2, 4'd0, to_after));
    for (int c = 0; c < 13; c++)
      if (m[c]) eq.push_back(mk(3'd3, 4'(c), to_after));
    eq.push_back(mk(3'd4, 4'd0, to_after));
    if (ovr_at > 0 && ovr_at < eq.size()) begin
      tmp       = eq[ovr_at];
      tmp.ovr   = 1'b1;
      eq[ovr_at] = tmp;
    end
    len = eq.size();
    foreach (eq[k]) sb_q.push_back(eq[k]);

    @(posedge clk); #1;
    frame_tick = 1'b1;
    ch_en_mask = m;
    done_clear = 1'b0;
    for (int cyc = 1; cyc <= len; cyc++) begin
      @(posedge clk); #1;
      frame_tick = (cyc == ovr_at);
      if (cyc == ovr_at) ch_en_mask = alt;
      done_clear = (cyc >= clr_wait + 1);
    end
    exp_to     = to_after;
    done_clear = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("drain", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL time_limit: simulation did not finish, got stuck expected finish");
    $fatal(1);
  end

  initial begin
    resetn           = 1'b0;
    frame_tick       = 1'b0;
    ch_en_mask       = '0;
    done_clear       = 1'b0;
    done_plot_letter = 1'b0;
    done_plot_graph  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'({ld_clear, ld_letter, ld_graph, graph_ch, busy, frame_done,
                              frame_overrun, timeout_err, current_state}), 32'd0);
    resetn           = 1'b1;
    done_clear       = 1'b1;
    done_plot_letter = 1'b1;
    done_plot_graph  = 1'b1;
    repeat (2) @(posedge clk);

    run_frame(13'h1FFF, 0, 13'h0000, 0);   // all channels, min frame = 16 cycles
    run_frame(13'h0105, 0, 13'h0000, 0);   // channels 0, 2, 8
    run_frame(13'h0000, 0, 13'h0000, 0);   // no graphs
    run_frame(13'h1FFF, 5, 13'h0001, 0);   // overrun in S_GRAPH, mask change ignored
    run_frame(13'h1000, 0, 13'h0000, 0);   // top channel only
`ifdef PLOT_SEQ_WATCHDOG_EN
    run_frame(13'h0003, 0, 13'h0000, 30);  // watchdog forces S_LETTER
`else
    run_frame(13'h0003, 0, 13'h0000, 20);  // waits for done_clear
`endif
    run_frame(13'h0010, 0, 13'h0000, 0);

    // Abort mid-frame in S_GRAPH ch 5
    sb_q.push_back(mk(3'd1, 4'd0, exp_to));
    sb_q.push_back(mk(3'd2, 4'd0, exp_to));
    for (int c = 0; c <= 5; c++) sb_q.push_back(mk(3'd3, 4'(c), exp_to));
    @(posedge clk); #1;
    frame_tick = 1'b1;
    ch_en_mask = 13'h1FFF;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      frame_tick = 1'b0;
    end
    #6;
    resetn = 1'b0;
    exp_to = 1'b0;
    #1;
    check("async_reset", 32'({ld_clear, ld_letter, ld_graph, graph_ch, busy, frame_done,
                              frame_overrun, timeout_err, current_state}), 32'd0);
    check("abort_drain", 32'(sb_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", 32'({ld_clear, ld_letter, ld_graph, busy, frame_done,
                             current_state}), 32'd0);
    #2;
    resetn = 1'b1;
    repeat (3) @(posedge clk);

    run_frame(13'h1001, 0, 13'h0000, 0);   // restart cleanly from S_CLEAR
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
